// File: rtl/mmio_pkg.sv
// mmio_pkg: shared address map defaults, status word layout and store byte-merge helper
package mmio_pkg;

    localparam logic [15:0] OUT0_ADDR = 16'd256;
    localparam logic [15:0] IN0_ADDR  = 16'd272;
    localparam logic [15:0] STAT_ADDR = 16'd320;

    localparam int STAT_IN_LSB  = 0;
    localparam int STAT_OUT_LSB = 16;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_PEND = 1'b1
    } out_state_e;

    // Only the byte lanes enabled by the store are replaced; the rest keep their old value.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return r;
    endfunction

    // True when two word-granular windows [a, a+4*na) and [b, b+4*nb) share any byte.
    function automatic bit windows_overlap(input int a, input int na, input int b, input int nb);
        return (a < b + 4 * nb) && (b < a + 4 * na);
    endfunction

endpackage

// File: rtl/mmio_in_fifo.sv
// mmio_in_fifo: power-of-2 depth FIFO with occupancy count, used per input channel
module mmio_in_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2; reset discards contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array needs no reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_port_bank.sv
// mmio_port_bank: memory-mapped output/input channel bank with status word on the data-memory bus
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int                NUM_IN    = 2,
    parameter int                NUM_OUT   = 2,
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(OUT0_ADDR),
    parameter logic [ADDR_W-1:0] IN_BASE   = ADDR_W'(IN0_ADDR),
    parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(mmio_pkg::STAT_ADDR),
    parameter int                IN_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         Addr,
    input  logic [DATA_W-1:0]         WriteData,
    input  logic [3:0]                ByteEn,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    output logic                      Hit,
    output logic [DATA_W-1:0]         ReadData,
    output logic                      io_stall,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready
);

    localparam int            AW     = ADDR_W - 2;
    localparam logic [AW-1:0] OUT_WI = OUT_BASE[ADDR_W-1:2];
    localparam logic [AW-1:0] IN_WI  = IN_BASE[ADDR_W-1:2];
    localparam logic [AW-1:0] STAT_WI = STAT_ADDR[ADDR_W-1:2];

    if (DATA_W != 32) begin : g_bad_width
        $error("mmio_port_bank: DATA_W must be 32");
    end
    if (NUM_IN < 1 || NUM_IN > 16 || NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_count
        $error("mmio_port_bank: NUM_IN and NUM_OUT must be 1..16");
    end
    if (IN_DEPTH < 2 || (IN_DEPTH & (IN_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mmio_port_bank: IN_DEPTH must be a power of 2 >= 2");
    end
    if (windows_overlap(int'(OUT_BASE), NUM_OUT, int'(IN_BASE), NUM_IN) ||
        windows_overlap(int'(OUT_BASE), NUM_OUT, int'(STAT_ADDR), 1) ||
        windows_overlap(int'(IN_BASE), NUM_IN, int'(STAT_ADDR), 1)) begin : g_bad_map
        $error("mmio_port_bank: address windows overlap");
    end

    logic [AW-1:0]      word_idx;
    logic               addr_lsb_unused;
    logic [NUM_OUT-1:0] out_hit;
    logic [NUM_IN-1:0]  in_hit;
    logic               stat_hit;
    logic               rd;
    logic [NUM_OUT-1:0] out_wr;
    logic [NUM_OUT-1:0] out_stall;
    logic [NUM_IN-1:0]  in_pop;
    logic [NUM_IN-1:0]  in_empty;
    logic [NUM_IN-1:0]  in_full;
    logic [DATA_W-1:0]  in_head [NUM_IN];
    logic [DATA_W-1:0]  status;
    logic               alive;

    assign word_idx        = Addr[ADDR_W-1:2];
    assign addr_lsb_unused = ^Addr[1:0];
    assign stat_hit        = word_idx == STAT_WI;
    assign rd              = MemRead && !MemWrite;
    assign out_wr          = out_hit & {NUM_OUT{MemWrite}};
    assign in_pop          = in_hit & {NUM_IN{rd}};
    assign Hit             = (|out_hit) || (|in_hit) || stat_hit;
    assign io_stall        = |out_stall;

    // Word-aligned decode of every channel address in the bank.
    always_comb begin
        out_hit = '0;
        in_hit  = '0;
        for (int k = 0; k < NUM_OUT; k++) out_hit[k] = word_idx == OUT_WI + AW'(k);
        for (int k = 0; k < NUM_IN; k++) in_hit[k] = word_idx == IN_WI + AW'(k);
    end

    // Status: FIFO nonempty flags in the low half, output-idle flags from bit 16.
    always_comb begin
        status = '0;
        for (int k = 0; k < NUM_IN; k++) status[STAT_IN_LSB + k] = !in_empty[k];
        for (int k = 0; k < NUM_OUT; k++) status[STAT_OUT_LSB + k] = !out_valid[k];
    end

    // Load data mux; empty FIFOs and unmapped addresses read as zero.
    always_comb begin
        ReadData = '0;
        if (stat_hit) ReadData = status;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (out_hit[k]) ReadData = out_data[k*DATA_W +: DATA_W];
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_hit[k]) ReadData = in_empty[k] ? '0 : in_head[k];
        end
    end

    // Holds in_ready low through reset and the cycle it is released in.
    always_ff @(posedge clk) begin
        if (!rst) alive <= 1'b0;
        else alive <= 1'b1;
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        out_state_e        state;
        out_state_e        state_nx;
        logic [DATA_W-1:0] data_q;

        assign out_valid[k]                   = state == OUT_PEND;
        assign out_stall[k]                   = out_wr[k] && state == OUT_PEND;
        assign out_data[k*DATA_W +: DATA_W]   = data_q;

        // Channel state and data register; data only changes while IDLE so it is stable when valid.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state  <= OUT_IDLE;
                data_q <= '0;
            end else begin
                state <= state_nx;
                if (state == OUT_IDLE && out_wr[k]) data_q <= byte_merge(data_q, WriteData, ByteEn);
            end
        end

        // A write while PEND stalls even if the consumer accepts this cycle; no bypass.
        always_comb begin
            state_nx = state;
            if (state == OUT_IDLE) state_nx = out_wr[k] ? OUT_PEND : OUT_IDLE;
            else state_nx = out_ready[k] ? OUT_IDLE : OUT_PEND;
        end
    end

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        mmio_in_fifo #(
            .DEPTH(IN_DEPTH),
            .WIDTH(DATA_W)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (in_valid[k] && in_ready[k]),
            .wdata(in_data[k*DATA_W +: DATA_W]),
            .pop  (in_pop[k]),
            .rdata(in_head[k]),
            .empty(in_empty[k]),
            .full (in_full[k])
        );

        assign in_ready[k] = rst && alive && !in_full[k];
    end

endmodule

// File: tb/tb_mmio_port_bank.sv
// tb_mmio_port_bank: table-driven cycle vectors plus a stall/release sequence for mmio_port_bank
module tb_mmio_port_bank;

    typedef struct {
        logic        rst;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mw;
        logic        mr;
        logic [1:0]  ordy;
        logic [1:0]  ivld;
        logic [31:0] idata;
        logic        e_hit;
        logic [31:0] e_rd;
        logic        e_stall;
        logic [1:0]  e_ovld;
        logic [1:0]  e_irdy;
        logic [31:0] e_od0;
        logic [31:0] e_od1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mw;
    logic        mr;
    logic        hit;
    logic [31:0] rdata;
    logic        io_stall;
    logic [63:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [31:0] idata;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;

    int   tests = 0;
    int   fails = 0;
    vec_t v[$];

    always #5 clk = ~clk;

    mmio_port_bank dut (
        .clk      (clk),
        .rst      (rst),
        .Addr     (addr),
        .WriteData(wdata),
        .ByteEn   (be),
        .MemWrite (mw),
        .MemRead  (mr),
        .Hit      (hit),
        .ReadData (rdata),
        .io_stall (io_stall),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_data  ({idata, idata}),
        .in_valid (in_valid),
        .in_ready (in_ready)
    );

    function automatic vec_t mk(int r, int a, int wd, int b, int w, int m, int ord, int ivl, int id,
                                int eh, int erd, int es, int eov, int eir, int o0, int o1);
        vec_t x;
        x.rst = 1'(r);       x.addr = 16'(a);    x.wdata = 32'(wd);  x.be = 4'(b);
        x.mw = 1'(w);        x.mr = 1'(m);       x.ordy = 2'(ord);   x.ivld = 2'(ivl);
        x.idata = 32'(id);   x.e_hit = 1'(eh);   x.e_rd = 32'(erd);  x.e_stall = 1'(es);
        x.e_ovld = 2'(eov);  x.e_irdy = 2'(eir); x.e_od0 = 32'(o0);  x.e_od1 = 32'(o1);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //          rst addr wdata        be  mw mr ordy ivld idata | hit rdata        stall ovld irdy od0          od1
        v.push_back(mk(1, 320, 0,           0, 0, 1, 0, 0, 0,    1, 32'h00030000, 0, 0, 0, 0,            0));
        v.push_back(mk(1, 0,   0,           0, 0, 1, 0, 0, 0,    0, 0,            0, 0, 3, 0,            0));
        v.push_back(mk(1, 256, 32'hDEADBEEF, 15, 1, 0, 0, 0, 0,  1, 0,            0, 0, 3, 0,            0));
        v.push_back(mk(1, 256, 32'hCAFEF00D, 15, 1, 0, 0, 0, 0,  1, 32'hDEADBEEF, 1, 1, 3, 32'hDEADBEEF, 0));
        v.push_back(mk(1, 256, 32'hCAFEF00D, 15, 1, 0, 1, 0, 0,  1, 32'hDEADBEEF, 1, 1, 3, 32'hDEADBEEF, 0));
        v.push_back(mk(1, 256, 32'hCAFEF00D, 15, 1, 0, 0, 0, 0,  1, 32'hDEADBEEF, 0, 0, 3, 32'hDEADBEEF, 0));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 1, 0, 0,    0, 0,            0, 1, 3, 32'hCAFEF00D, 0));
        v.push_back(mk(1, 260, 32'h12345678, 15, 1, 0, 0, 0, 0,  1, 0,            0, 0, 3, 32'hCAFEF00D, 0));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 2, 0, 0,    0, 0,            0, 2, 3, 32'hCAFEF00D, 32'h12345678));
        v.push_back(mk(1, 260, 32'h000000AF, 1, 1, 0, 0, 0, 0,   1, 32'h12345678, 0, 0, 3, 32'hCAFEF00D, 32'h12345678));
        v.push_back(mk(1, 260, 0,           0, 0, 1, 0, 0, 0,    1, 32'h123456AF, 0, 2, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 320, 0,           0, 0, 1, 2, 0, 0,    1, 32'h00010000, 0, 2, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 258, 0,           0, 0, 1, 0, 0, 0,    1, 32'hCAFEF00D, 0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 272, 32'h55,      15, 1, 0, 0, 0, 0,   1, 0,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 1, 1,    0, 0,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 1, 2,    0, 0,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 1, 3,    0, 0,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 1, 4,    0, 0,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 1, 5,    0, 0,            0, 0, 2, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 272, 0,           0, 0, 1, 0, 1, 5,    1, 1,            0, 0, 2, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 272, 0,           0, 0, 1, 0, 0, 0,    1, 2,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 272, 0,           0, 0, 1, 0, 0, 0,    1, 3,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 272, 0,           0, 0, 1, 0, 0, 0,    1, 4,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 272, 0,           0, 0, 1, 0, 0, 0,    1, 0,            0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 320, 0,           0, 0, 1, 0, 0, 0,    1, 32'h00030000, 0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 276, 0,           0, 0, 1, 0, 2, 32'h77, 1, 0,          0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 276, 0,           0, 0, 1, 0, 0, 0,    1, 32'h77,       0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 2, 32'h88, 0, 0,          0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 276, 0,           15, 1, 1, 0, 0, 0,   1, 32'h88,       0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 276, 0,           0, 0, 1, 0, 0, 0,    1, 32'h88,       0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 320, 0,           0, 0, 1, 0, 0, 0,    1, 32'h00030000, 0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 256, 32'h11,      15, 1, 0, 0, 1, 32'hA, 1, 32'hCAFEF00D, 0, 0, 3, 32'hCAFEF00D, 32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 1, 32'hB, 0, 0,           0, 1, 3, 32'h11,       32'h123456AF));
        v.push_back(mk(1, 0,   0,           0, 0, 0, 0, 1, 32'hC, 0, 0,           0, 1, 3, 32'h11,       32'h123456AF));
        v.push_back(mk(1, 320, 0,           0, 0, 1, 0, 0, 0,    1, 32'h00020001, 0, 1, 3, 32'h11,       32'h123456AF));
        v.push_back(mk(0, 0,   0,           0, 0, 0, 0, 0, 0,    0, 0,            0, 1, 0, 32'h11,       32'h123456AF));
        v.push_back(mk(1, 320, 0,           0, 0, 1, 0, 0, 0,    1, 32'h00030000, 0, 0, 0, 0,            0));
        v.push_back(mk(1, 272, 0,           0, 0, 1, 0, 0, 0,    1, 0,            0, 0, 3, 0,            0));

        rst = 1'b0; addr = '0; wdata = '0; be = '0; mw = 1'b0; mr = 1'b0;
        out_ready = '0; idata = '0; in_valid = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            rst = v[i].rst; addr = v[i].addr; wdata = v[i].wdata; be = v[i].be;
            mw = v[i].mw; mr = v[i].mr; out_ready = v[i].ordy;
            in_valid = v[i].ivld; idata = v[i].idata;
            #2;
            check($sformatf("v%0d_hit", i), 32'(hit), 32'(v[i].e_hit));
            check($sformatf("v%0d_rdata", i), rdata, v[i].e_rd);
            check($sformatf("v%0d_stall", i), 32'(io_stall), 32'(v[i].e_stall));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(v[i].e_ovld));
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(v[i].e_irdy));
            check($sformatf("v%0d_out_data0", i), out_data[31:0], v[i].e_od0);
            check($sformatf("v%0d_out_data1", i), out_data[63:32], v[i].e_od1);
        end

        @(negedge clk);
        rst = 1'b1; addr = 16'd256; wdata = 32'h1; be = 4'hF; mw = 1'b1; mr = 1'b0;
        out_ready = '0; in_valid = '0;
        @(negedge clk);
        wdata = 32'h2;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("seq_stall_hold%0d", c), 32'(io_stall), 32'h1);
            check($sformatf("seq_data_hold%0d", c), out_data[31:0], 32'h1);
            @(negedge clk);
        end
        out_ready = 2'b01;
        #2;
        check("seq_stall_ready_same_cycle", 32'(io_stall), 32'h1);
        @(negedge clk);
        out_ready = '0;
        n = 0;
        while (io_stall && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("seq_release_cycles", 32'(n), 32'h0);
        #2;
        check("seq_idle_before_write", 32'(out_valid), 32'h0);
        check("seq_data_before_write", out_data[31:0], 32'h1);
        @(negedge clk);
        mw = 1'b0;
        #2;
        check("seq_write_done_valid", 32'(out_valid), 32'h1);
        check("seq_write_done_data", out_data[31:0], 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
